// File: rtl/tut_nios_oci_access_arbiter.sv
// Round-robin arbiter sharing the OCI debug memory/register port between a JTAG
// command FIFO and a CPU req/ack requester. Optional ISSUE timeout: OCI_ARB_TIMEOUT_EN.
module tut_nios_oci_access_arbiter #(
    parameter int unsigned AW              = 7,
    parameter int unsigned JTAG_FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          jtag_cmd_valid,
    input  logic          jtag_cmd_we,
    input  logic [AW-1:0] jtag_cmd_addr,
    input  logic [31:0]   jtag_cmd_wdata,
    output logic          jtag_fifo_full,
    output logic          jtag_overflow,
    output logic          jtag_rsp_valid,
    output logic [31:0]   jtag_rsp_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_ack,
    output logic [31:0]   cpu_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic          busy,
    output logic          err
);

    localparam int unsigned PW = $clog2(JTAG_FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } cmd_t;

    state_t       state_q, state_d;
    logic         rr_last_cpu_q, rr_last_cpu_d;
    logic         owner_jtag_q, owner_jtag_d;
    cmd_t         iss_q, iss_d;
    logic [31:0]  jtag_rdata_q, jtag_rdata_d;
    logic [31:0]  cpu_rdata_q, cpu_rdata_d;
    logic         overflow_q, overflow_d;

    cmd_t         fifo_q [JTAG_FIFO_DEPTH];
    logic [PW:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]  rd_ptr_q, rd_ptr_d;
    logic         fifo_empty, fifo_full;
    logic         jtag_pend, pop, push_ok;
    cmd_t         in_cmd, head_cmd;

    assign in_cmd     = {jtag_cmd_we, jtag_cmd_addr, jtag_cmd_wdata};
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    // An empty FIFO forwards a same-cycle strobe straight to the arbiter, so a
    // JTAG strobe and cpu_req arriving together are a genuine tie.
    assign head_cmd  = fifo_empty ? in_cmd : fifo_q[rd_ptr_q[PW-1:0]];
    assign jtag_pend = !fifo_empty || jtag_cmd_valid;
    assign push_ok   = jtag_cmd_valid && (!fifo_full || pop);

`ifdef OCI_ARB_TIMEOUT_EN
    localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;
    assign err = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign err = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        rr_last_cpu_d = rr_last_cpu_q;
        owner_jtag_d  = owner_jtag_q;
        iss_d         = iss_q;
        jtag_rdata_d  = jtag_rdata_q;
        cpu_rdata_d   = cpu_rdata_q;
        pop           = 1'b0;
`ifdef OCI_ARB_TIMEOUT_EN
        tcnt_d        = tcnt_q;
        err_d         = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
`ifdef OCI_ARB_TIMEOUT_EN
                tcnt_d = '0;
`endif
                if (jtag_pend && (!cpu_req || rr_last_cpu_q)) begin
                    pop           = 1'b1;
                    owner_jtag_d  = 1'b1;
                    rr_last_cpu_d = 1'b0;
                    iss_d         = head_cmd;
                    state_d       = S_ISSUE;
                end else if (cpu_req) begin
                    owner_jtag_d  = 1'b0;
                    rr_last_cpu_d = 1'b1;
                    iss_d         = {cpu_we, cpu_addr, cpu_wdata};
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_ack) begin
                    if (owner_jtag_q) jtag_rdata_d = mem_rdata;
                    else              cpu_rdata_d  = mem_rdata;
                    state_d = S_RESP;
                end
`ifdef OCI_ARB_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    if (owner_jtag_q) jtag_rdata_d = '0;
                    else              cpu_rdata_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
`endif
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        if (jtag_cmd_valid && !push_ok) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rr_last_cpu_q <= 1'b1;
            owner_jtag_q  <= 1'b0;
            iss_q         <= '0;
            jtag_rdata_q  <= '0;
            cpu_rdata_q   <= '0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
`ifdef OCI_ARB_TIMEOUT_EN
            tcnt_q        <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rr_last_cpu_q <= rr_last_cpu_d;
            owner_jtag_q  <= owner_jtag_d;
            iss_q         <= iss_d;
            jtag_rdata_q  <= jtag_rdata_d;
            cpu_rdata_q   <= cpu_rdata_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
`ifdef OCI_ARB_TIMEOUT_EN
            tcnt_q        <= tcnt_d;
            err_q         <= err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wr_ptr_q[PW-1:0]] <= in_cmd;
    end

    assign mem_req        = (state_q == S_ISSUE);
    assign mem_we         = iss_q.we;
    assign mem_addr       = iss_q.addr;
    assign mem_wdata      = iss_q.wdata;
    assign jtag_rsp_valid = (state_q == S_RESP) && owner_jtag_q;
    assign cpu_ack        = (state_q == S_RESP) && !owner_jtag_q;
    assign jtag_rsp_rdata = jtag_rdata_q;
    assign cpu_rdata      = cpu_rdata_q;
    assign jtag_fifo_full = fifo_full;
    assign jtag_overflow  = overflow_q;
    assign busy           = (state_q != S_IDLE) || !fifo_empty;

endmodule
